cpu_trace_buffer: RTL

CPU_TRACE_BUFFER -- requirements
Module: cpu_trace_buffer

---
 rtl/cpu_trace_buffer_if.sv | 37 +++
 rtl/cpu_trace_buffer.sv | 104 ++++++++++
 2 files changed

// File: rtl/cpu_trace_buffer_if.sv
// Bundle of commit-capture inputs and trace FIFO outputs for cpu_trace_buffer.
interface cpu_trace_buffer_if #(
  parameter int DEPTH = 8,
  parameter int SEQW  = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]     pc;
  logic [31:0]     instr;
  logic [31:0]     alu_result;
  logic            reg_write_en;
  logic            trace_en;
  logic            clear_ovf;
  logic            out_ready;
  logic            out_valid;
  logic [31:0]     out_pc;
  logic [31:0]     out_instr;
  logic [31:0]     out_result;
  logic [SEQW-1:0] out_seq;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
  logic            overflow;
  logic [SEQW-1:0] drop_count;

  modport master (
    output pc, instr, alu_result, reg_write_en, trace_en, clear_ovf, out_ready,
    input  out_valid, out_pc, out_instr, out_result, out_seq, count, full, empty,
           overflow, drop_count
  );

  modport slave (
    input  pc, instr, alu_result, reg_write_en, trace_en, clear_ovf, out_ready,
    output out_valid, out_pc, out_instr, out_result, out_seq, count, full, empty,
           overflow, drop_count
  );
endinterface

// File: rtl/cpu_trace_buffer.sv
// First-word-fall-through trace FIFO of retired commits with sequence tagging
// and sticky, saturating drop accounting.
module cpu_trace_buffer #(
  parameter int DEPTH = 8,
  parameter int SEQW  = 16
) (
  input  logic             clk,
  input  logic             reset,
  cpu_trace_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  function automatic logic [SEQW-1:0] sat_inc(input logic [SEQW-1:0] v);
    return (v == {SEQW{1'b1}}) ? v : v + SEQW'(1);
  endfunction

  // Assertion is immediate through the flop's async clear; release lands on a clock edge.
  logic rst_sync_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= 1'b0;
    else        rst_sync_q <= 1'b1;
  end

  logic [31:0]     pc_mem  [DEPTH];
  logic [31:0]     ins_mem [DEPTH];
  logic [31:0]     res_mem [DEPTH];
  logic [SEQW-1:0] seq_mem [DEPTH];

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [SEQW-1:0] seq_q, seq_d;
  logic            ovf_q, ovf_d;
  logic [SEQW-1:0] drop_q, drop_d;

  logic capture, push, pop, drop, is_full, is_empty;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));
  assign capture  = bus.trace_en & bus.reg_write_en;
  assign pop      = ~is_empty & bus.out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push     = capture & (~is_full | pop);
  assign drop     = capture & ~push;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    seq_d    = seq_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;
    if (push)    wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
    if (capture) seq_d    = seq_q + SEQW'(1);
    if (drop) begin
      ovf_d  = 1'b1;
      drop_d = bus.clear_ovf ? SEQW'(1) : sat_inc(drop_q);
    end else if (bus.clear_ovf) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      seq_q    <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      seq_q    <= seq_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  // Entry storage carries no reset; occupancy decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]  <= bus.pc;
      ins_mem[wr_ptr_q] <= bus.instr;
      res_mem[wr_ptr_q] <= bus.alu_result;
      seq_mem[wr_ptr_q] <= seq_q;
    end
  end

  assign bus.out_valid  = ~is_empty;
  assign bus.out_pc     = is_empty ? '0 : pc_mem[rd_ptr_q];
  assign bus.out_instr  = is_empty ? '0 : ins_mem[rd_ptr_q];
  assign bus.out_result = is_empty ? '0 : res_mem[rd_ptr_q];
  assign bus.out_seq    = is_empty ? '0 : seq_mem[rd_ptr_q];
  assign bus.count      = count_q;
  assign bus.full       = is_full;
  assign bus.empty      = is_empty;
  assign bus.overflow   = ovf_q;
  assign bus.drop_count = drop_q;
endmodule
